stepdir_receiver: RTL and testbench
===================================

STEPDIR_RECEIVER -- requirements
Module: stepdir_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: number of consecutive equal synchronised samples needed to accept a new STP/DIR level.
REQ-002 SHALL have parameter TIMEOUT, default 13500000: number of sysclk cycles without a step after which the axis is reported stopped.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: counting enabled when high.
REQ-006 SHALL have port STP, input, 1 bit: external step pulse, asynchronous to sysclk.
REQ-007 SHALL have port DIR, input, 1 bit: external direction, asynchronous; 1 = positive.
REQ-008 SHALL have port load, input, 1 bit: one-cycle preset strobe.
REQ-009 SHALL have port load_value, input, signed 32 bits: preset value for position.
REQ-010 SHALL have port position, output, signed 32 bits: accumulated step count.
REQ-011 SHALL have port period, output, signed 32 bits: sysclk cycles between the last two steps; negative when DIR = 0; 0 when stopped.
REQ-012 SHALL have port step_strobe, output, 1 bit: one-cycle pulse per accepted step.
REQ-013 SHALL have port dir_out, output, 1 bit: filtered DIR level.

Function
REQ-014 STP and DIR SHALL each pass through a 2-flop synchroniser, then the identical filter path, so the two signals stay cycle-aligned.
REQ-015 An accepted step SHALL be a filtered STP 0->1 transition; step_strobe high for exactly that cycle.
REQ-016 Without the filter, position SHALL change on the 3rd sysclk edge after STP is first sampled high; with the filter, FILTER_LEN cycles later.
REQ-017 On a step, position SHALL add +1 when filtered DIR = 1 and -1 when 0; 32-bit two's-complement wrap (0x7FFFFFFF+1 -> 0x80000000), no saturation.
REQ-018 Interval counter SHALL increment each cycle, saturating at TIMEOUT; on a step it SHALL reset to 0, and period SHALL take +(count+1) or -(count+1) per DIR.
REQ-019 When the interval counter reaches TIMEOUT, period SHALL become 0 and the block SHALL be in state STOPPED.
REQ-020 States: STOPPED (reset state) and RUNNING. STOPPED->RUNNING on a step, with period left 0 because that interval is invalid. RUNNING->STOPPED on timeout.
REQ-021 load SHALL set position = load_value on the next edge; load beats a simultaneous step, which SHALL be dropped from position and still update period/strobe.
REQ-022 enable low SHALL freeze position, suppress step_strobe, clear period to 0, and force STOPPED; synchronisers keep running.
REQ-023 Steps closer than the filter/synchroniser resolution SHALL be lost, never double-counted.

Reset
REQ-024 rst_n low SHALL clear position, period, step_strobe, dir_out, the interval counter, and all synchroniser/filter flops to 0, and set state STOPPED, asynchronously.
REQ-025 Reset SHALL be released synchronously (2-flop deassert sync); a step in progress during reset SHALL be discarded.

Configuration
REQ-026 With macro STEPDIR_RECEIVER_FILTER_EN defined, the FILTER_LEN glitch filter SHALL be present.
REQ-027 Without STEPDIR_RECEIVER_FILTER_EN, synchronised signals SHALL feed edge detection directly, FILTER_LEN SHALL be ignored, and latency SHALL follow REQ-016.

Structure
REQ-028 A shared package SHALL hold the STOPPED/RUNNING state enum, the position/period width constant (32), and the default TIMEOUT.
REQ-029 The synchroniser plus filter SHALL be one sub-module, sync_filter, instantiated twice (STP, DIR).

Verification
REQ-030 Reset, then 10 STP pulses (DIR = 1, 20 cycles apart) -> position = 10, 10 step_strobe pulses, period = +20 after the 2nd pulse.
REQ-031 DIR = 0, 3 pulses from position 0 -> position = -3 (0xFFFFFFFD), period negative.
REQ-032 load_value = 0x7FFFFFFF, one DIR = 1 step -> position = 0x80000000; load coincident with a step edge -> position = load_value.
REQ-033 Filter enabled, FILTER_LEN = 4, 2-cycle STP glitch -> no step, position unchanged.
REQ-034 TIMEOUT = 100, no step for 100 cycles -> period = 0; the next step leaves period 0, and the following step 30 cycles later -> period = 30.
REQ-035 rst_n asserted mid-stream -> all outputs 0 immediately; enable low during pulses -> position frozen, period 0.

Source files
------------

// File: rtl/stepdir_receiver_pkg.sv
// Shared types and constants for the STEP/DIR receiver and its input conditioning.
package stepdir_receiver_pkg;

    localparam int SDR_WIDTH           = 32;
    localparam int SDR_TIMEOUT_DEFAULT = 13500000;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } sdr_state_e;

    // Step interval signed by travel direction: positive when dir = 1.
    function automatic logic signed [SDR_WIDTH-1:0] sdr_signed_period(
        input logic [SDR_WIDTH-1:0] mag,
        input logic                 dir
    );
        return dir ? $signed(mag) : -$signed(mag);
    endfunction

endpackage

// File: rtl/stepdir_receiver_sync_filter.sv
// Two-flop synchroniser plus optional level filter (present when STEPDIR_RECEIVER_FILTER_EN is defined).
// STP and DIR each use one instance so both paths carry identical latency.
module sync_filter
    import stepdir_receiver_pkg::*;
`ifdef STEPDIR_RECEIVER_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic sysclk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level
);

    logic [1:0] r_sync;

    // Metastability guard; only r_sync[1] is used downstream.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

`ifdef STEPDIR_RECEIVER_FILTER_EN
    localparam int            CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;

    // A new level is accepted after FILTER_LEN consecutive samples disagree with the current one.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_level = r_level;
`else
    assign o_level = r_sync[1];
`endif

endmodule

// File: rtl/stepdir_receiver.sv
// STEP/DIR receiver: position accumulator, signed step period and stop detection.
// Optional glitch filter on STP/DIR is enabled by defining STEPDIR_RECEIVER_FILTER_EN.
module stepdir_receiver
    import stepdir_receiver_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = SDR_TIMEOUT_DEFAULT
)(
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        STP,
    input  logic                        DIR,
    input  logic                        load,
    input  logic signed [SDR_WIDTH-1:0] load_value,
    output logic signed [SDR_WIDTH-1:0] position,
    output logic signed [SDR_WIDTH-1:0] period,
    output logic                        step_strobe,
    output logic                        dir_out
);

    localparam int            IW          = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TMO         = IW'(TIMEOUT);
    localparam int            SETTLE      = FILTER_LEN + 4;
    localparam int            SW          = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_DONE = SW'(SETTLE);

    logic [1:0]                  r_rst_sync;
    logic                        w_rst_n;
    logic                        w_stp_f;
    logic                        w_dir_f;
    logic                        r_stp_prev;
    logic                        r_armed;
    logic [SW-1:0]               r_settle;
    logic                        w_step;
    sdr_state_e                  r_state;
    sdr_state_e                  w_state_nxt;
    logic signed [SDR_WIDTH-1:0] r_position;
    logic signed [SDR_WIDTH-1:0] w_position_nxt;
    logic signed [SDR_WIDTH-1:0] r_period;
    logic signed [SDR_WIDTH-1:0] w_period_nxt;
    logic                        r_strobe;
    logic                        w_strobe_nxt;
    logic                        r_dir_out;
    logic [IW-1:0]               r_interval;
    logic [IW-1:0]               w_interval_inc;
    logic [IW-1:0]               w_interval_nxt;
    logic [SDR_WIDTH-1:0]        w_mag;

    // Reset asserts asynchronously and is released two edges later in the sysclk domain.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    sync_filter
`ifdef STEPDIR_RECEIVER_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_stp_filt (.sysclk(sysclk), .rst_n(w_rst_n), .i_d(STP), .o_level(w_stp_f));

    sync_filter
`ifdef STEPDIR_RECEIVER_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_dir_filt (.sysclk(sysclk), .rst_n(w_rst_n), .i_d(DIR), .o_level(w_dir_f));

    // Edge detect; arming waits for the pipeline to settle and STP to read low,
    // so a pulse already in flight across reset release never counts.
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stp_prev <= 1'b0;
            r_settle   <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_stp_prev <= w_stp_f;
            if (r_settle != SETTLE_DONE) begin
                r_settle <= r_settle + SW'(1);
            end else if (!w_stp_f) begin
                r_armed  <= 1'b1;
            end
        end
    end

    assign w_step         = w_stp_f & ~r_stp_prev & r_armed;
    assign w_mag          = SDR_WIDTH'(r_interval) + 32'd1;
    assign w_interval_inc = (r_interval == TMO) ? TMO : r_interval + IW'(1);
    assign w_position_nxt = load ? load_value :
                            (enable && w_step) ? (w_dir_f ? r_position + 32'sd1 : r_position - 32'sd1) :
                            r_position;

    // Next-state and period/interval/strobe decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_period_nxt   = r_period;
        w_strobe_nxt   = 1'b0;
        w_interval_nxt = w_interval_inc;
        if (!enable) begin
            w_state_nxt    = ST_STOPPED;
            w_period_nxt   = '0;
            w_interval_nxt = '0;
        end else if (w_step) begin
            w_strobe_nxt   = 1'b1;
            w_interval_nxt = '0;
            case (r_state)
                ST_RUNNING: begin
                    w_period_nxt = sdr_signed_period(w_mag, w_dir_f);
                end
                ST_STOPPED: begin
                    w_state_nxt  = ST_RUNNING;
                    w_period_nxt = '0;
                end
                default: begin
                    w_state_nxt  = ST_STOPPED;
                    w_period_nxt = '0;
                end
            endcase
        end else if (w_interval_inc == TMO) begin
            w_state_nxt  = ST_STOPPED;
            w_period_nxt = '0;
        end else begin
            w_state_nxt  = r_state;
        end
    end

    // Architectural state and registered outputs.
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_STOPPED;
            r_position <= '0;
            r_period   <= '0;
            r_strobe   <= 1'b0;
            r_dir_out  <= 1'b0;
            r_interval <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_position <= w_position_nxt;
            r_period   <= w_period_nxt;
            r_strobe   <= w_strobe_nxt;
            r_dir_out  <= w_dir_f;
            r_interval <= w_interval_nxt;
        end
    end

    assign position    = r_position;
    assign period      = r_period;
    assign step_strobe = r_strobe;
    assign dir_out     = r_dir_out;

endmodule

// File: tb/tb_stepdir_receiver.sv
// Self-checking bench for stepdir_receiver: directed scenarios plus random STP/DIR/enable/load
// traffic, all compared each cycle against a behavioural model built from sample history.
module tb_stepdir_receiver;

    localparam int FL   = 4;
    localparam int TMO  = 100;
    localparam int MAXE = 8192;
`ifdef STEPDIR_RECEIVER_FILTER_EN
    localparam int LAT = 2 + FL;
`else
    localparam int LAT = 2;
`endif

    logic               sysclk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               STP;
    logic               DIR;
    logic               load;
    logic signed [31:0] load_value;
    logic signed [31:0] position;
    logic signed [31:0] period;
    logic               step_strobe;
    logic               dir_out;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    bit          s_hist  [2][MAXE];
    bit          lv_hist [2][MAXE];
    int          n;
    logic [31:0] m_pos;
    int          m_period;
    bit          m_running;
    int          m_last;

    stepdir_receiver #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .STP(STP), .DIR(DIR),
        .load(load), .load_value(load_value), .position(position), .period(period),
        .step_strobe(step_strobe), .dir_out(dir_out)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Filtered level after edge k: a new value wins once the last FL synchroniser outputs all disagree with the old one.
    function automatic bit next_level(input int w, input int k);
`ifdef STEPDIR_RECEIVER_FILTER_EN
        bit flip = 1'b1;
        for (int j = 0; j < FL; j++)
            if (s_hist[w][k-2-j] == lv_hist[w][k-1]) flip = 1'b0;
        return flip ? ~lv_hist[w][k-1] : lv_hist[w][k-1];
`else
        return s_hist[w][k-1];
`endif
    endfunction

    task automatic model_init();
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < MAXE; k++) begin
                s_hist[w][k]  = 1'b0;
                lv_hist[w][k] = 1'b0;
            end
        n = 16; m_pos = 32'd0; m_period = 0; m_running = 1'b0; m_last = 0;
    endtask

    task automatic cycle();
        bit          step, d, en, ld, m_strobe;
        logic [31:0] ldv;
        s_hist[0][n] = STP; s_hist[1][n] = DIR;
        en = enable; ld = load; ldv = load_value;
        @(posedge sysclk); #1;
        for (int w = 0; w < 2; w++) lv_hist[w][n] = next_level(w, n);
        step     = lv_hist[0][n-1] & ~lv_hist[0][n-2];
        d        = lv_hist[1][n-1];
        m_strobe = 1'b0;
        if (!en) begin
            m_running = 1'b0; m_period = 0;
        end else if (step) begin
            m_strobe = 1'b1;
            if (m_running) m_period = d ? (n - m_last) : -(n - m_last);
            else begin m_running = 1'b1; m_period = 0; end
            m_last = n;
            m_pos  = d ? m_pos + 32'd1 : m_pos - 32'd1;
        end else if (m_running && (n - m_last) >= TMO) begin
            m_running = 1'b0; m_period = 0;
        end
        if (ld) m_pos = ldv;
        if (step_strobe) strobes++;
        chk("position", position, m_pos);
        chk("period", period, 32'(m_period));
        chk("step_strobe", 32'(step_strobe), 32'(m_strobe));
        chk("dir_out", 32'(dir_out), 32'(d));
        n++;
    endtask

    task automatic ticks(input int k);
        repeat (k) cycle();
    endtask

    task automatic pulse(input int hi, input int lo);
        STP = 1'b1; ticks(hi);
        STP = 1'b0; ticks(lo);
    endtask

    initial begin
        int          s0;
        int          hold;
        logic [31:0] p0;
        rst_n = 1'b0; enable = 1'b1; STP = 1'b0; DIR = 1'b0; load = 1'b0; load_value = 32'sd0;
        #12;
        chk("reset_position", position, 32'd0);
        chk("reset_period", period, 32'd0);
        chk("reset_strobe", 32'(step_strobe), 32'd0);
        chk("reset_dir_out", 32'(dir_out), 32'd0);
        #20 rst_n = 1'b1;
        model_init();
        ticks(20);

        // Ten forward steps, 20 cycles apart.
        DIR = 1'b1; ticks(4); strobes = 0;
        repeat (10) pulse(6, 14);
        chk("fwd10_position", position, 32'd10);
        chk("fwd10_strobes", 32'(strobes), 32'd10);
        chk("fwd10_period", period, 32'd20);

        // Three reverse steps from zero.
        load_value = 32'sd0; load = 1'b1; ticks(1); load = 1'b0;
        DIR = 1'b0; ticks(4);
        repeat (3) pulse(6, 14);
        chk("rev3_position", position, 32'hFFFF_FFFD);
        chk("rev3_period_sign", 32'(period[31]), 32'd1);

        // Positive wrap, then a load landing on the same edge as a step.
        load_value = 32'sh7FFF_FFFF; load = 1'b1; ticks(1); load = 1'b0;
        DIR = 1'b1; ticks(4);
        pulse(6, 14);
        chk("wrap_position", position, 32'h8000_0000);
        load_value = 32'sh1234_5678;
        STP = 1'b1; ticks(LAT);
        load = 1'b1; ticks(1); load = 1'b0;
        chk("load_vs_step_position", position, 32'h1234_5678);
        chk("load_vs_step_strobe", 32'(step_strobe), 32'd1);
        ticks(5); STP = 1'b0; ticks(14);

        s0 = strobes;
`ifdef STEPDIR_RECEIVER_FILTER_EN
        STP = 1'b1; ticks(2); STP = 1'b0; ticks(12);
        chk("glitch_position", position, 32'h1234_5678);
        chk("glitch_strobes", 32'(strobes), 32'(s0));
`else
        STP = 1'b1; ticks(1); STP = 1'b0; ticks(12);
        chk("short_pulse_position", position, 32'h1234_5679);
        chk("short_pulse_strobes", 32'(strobes), 32'(s0 + 1));
`endif

        // Timeout, restart with an invalid interval, then a 30-cycle interval.
        ticks(110);
        chk("timeout_period", period, 32'd0);
        pulse(6, 24);
        chk("restart_period", period, 32'd0);
        pulse(6, 24);
        chk("after_restart_period", period, 32'd30);

        // Random traffic.
        hold = 0;
        repeat (400) begin
            if (hold == 0) begin
                STP  = 1'($urandom_range(0, 1));
                DIR  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            enable     = ($urandom_range(0, 29) != 0);
            load       = ($urandom_range(0, 39) == 0);
            load_value = $urandom;
            cycle();
        end
        enable = 1'b1; load = 1'b0; STP = 1'b0; ticks(20);

        // Disabled: pulses are ignored.
        enable = 1'b0; p0 = m_pos; s0 = strobes; DIR = 1'b1;
        repeat (3) pulse(6, 14);
        chk("disabled_position", position, p0);
        chk("disabled_period", period, 32'd0);
        chk("disabled_strobes", 32'(strobes), 32'(s0));
        enable = 1'b1; ticks(5);

        // Mid-stream reset with a pulse held across release.
        load_value = 32'sh55; load = 1'b1; ticks(1); load = 1'b0;
        DIR = 1'b0; STP = 1'b1; ticks(1);
        rst_n = 1'b0; #1;
        chk("midreset_position", position, 32'd0);
        chk("midreset_period", period, 32'd0);
        chk("midreset_strobe", 32'(step_strobe), 32'd0);
        chk("midreset_dir_out", 32'(dir_out), 32'd0);
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        s0 = strobes;
        repeat (30) begin @(posedge sysclk); #1; if (step_strobe) strobes++; end
        STP = 1'b0;
        repeat (20) begin @(posedge sysclk); #1; if (step_strobe) strobes++; end
        chk("discard_position", position, 32'd0);
        chk("discard_strobes", 32'(strobes), 32'(s0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
